// File: rtl/bsg_hash_bank_pkg.sv
// Shared definitions for the forward address-to-bank hash and its reverse/routing counterparts.
package bsg_hash_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bsg_hash_bank_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bsg_hash_bank_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract banks_p if it fits.
module bsg_hash_bank_div_step
  import bsg_hash_bank_pkg::*;
#(
  parameter int banks_p = 3,
  localparam int rem_width_lp = safe_clog2(banks_p) + 1
) (
  input  logic [rem_width_lp-1:0] rem_i,
  input  logic                    bit_i,
  output logic [rem_width_lp-1:0] rem_o,
  output logic                    q_o
);

  localparam int shift_width_lp = rem_width_lp + 1;

  logic [shift_width_lp-1:0] shifted;
  logic [shift_width_lp-1:0] divisor;

  assign shifted = {rem_i, bit_i};
  assign divisor = shift_width_lp'(banks_p);
  assign q_o     = (shifted >= divisor);
  // A kept remainder is always below banks_p, so dropping the top bit loses nothing.
  assign rem_o   = q_o ? rem_width_lp'(shifted - divisor) : shifted[rem_width_lp-1:0];

endmodule

// File: rtl/bsg_hash_bank_iter.sv
// Splits addr into bank/index with addr = index*banks_p + bank; pow2 banks answer 1 cycle after accept, others after width_p+1.
// One job at a time: ready_o only in IDLE, result held in DONE until yumi_i.
module bsg_hash_bank_iter
  import bsg_hash_bank_pkg::*;
#(
  parameter int banks_p = 3,
  parameter int width_p = 32,
  localparam int bank_width_lp = safe_clog2(banks_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [width_p-1:0]       addr_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [bank_width_lp-1:0] bank_o,
  output logic [width_p-1:0]       index_o,
  output logic                     v_o,
  input  logic                     yumi_i
);

  localparam bit pow2_lp = is_pow2(banks_p);

  bsg_hash_bank_state_e state_r, state_n;
  logic accept;
  logic last_step;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    accept  = 1'b0;
    ready_o = 1'b0;
    v_o     = 1'b0;
    case (state_r)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          accept  = 1'b1;
          state_n = pow2_lp ? DONE : BUSY;
        end
      end
      BUSY: if (last_step) state_n = DONE;
      DONE: begin
        v_o = 1'b1;
        if (yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  if (pow2_lp) begin : g_pow2
    localparam int shift_lp = $clog2(banks_p);
    logic [width_p-1:0] addr_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)  addr_r <= '0;
      else if (accept) addr_r <= addr_i;
    end

    assign index_o   = addr_r >> shift_lp;
    assign last_step = 1'b0;
    if (banks_p == 1) begin : g_one
      assign bank_o = '0;
    end else begin : g_slice
      assign bank_o = addr_r[bank_width_lp-1:0];
    end
  end else begin : g_div
    localparam int cnt_width_lp = safe_clog2(width_p + 1);
    logic [width_p-1:0]      quot_r;
    logic [bank_width_lp:0]  rem_r, rem_next;
    logic                    q_bit;
    logic [cnt_width_lp-1:0] cnt_r;

    // The quotient register starts as the dividend and fills with quotient bits from the bottom.
    bsg_hash_bank_div_step #(.banks_p(banks_p)) step (
      .rem_i (rem_r),
      .bit_i (quot_r[width_p-1]),
      .rem_o (rem_next),
      .q_o   (q_bit)
    );

    assign last_step = (cnt_r == cnt_width_lp'(width_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        quot_r <= '0;
        rem_r  <= '0;
        cnt_r  <= '0;
      end else if (accept) begin
        quot_r <= addr_i;
        rem_r  <= '0;
        cnt_r  <= '0;
      end else if (state_r == BUSY) begin
        quot_r <= {quot_r[width_p-2:0], q_bit};
        rem_r  <= rem_next;
        cnt_r  <= cnt_r + cnt_width_lp'(1);
      end
    end

    assign index_o = quot_r;
    assign bank_o  = rem_r[bank_width_lp-1:0];
  end

  assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_hash_bank_iter.sv
// Scoreboarded bench over several bank counts: stimulus pushes div/mod expectations, a monitor consumes results.
module tb_bsg_hash_bank_iter;

  localparam int NI     = 6;
  localparam int N_RAND = 300;
  localparam int WIDTH  = 32;

  function automatic int bk(input int i);
    case (i)
      0:       return 3;
      1:       return 4;
      2:       return 1;
      3:       return 5;
      4:       return 7;
      default: return 8;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset_n;
  logic [NI-1:0][WIDTH-1:0] addr;
  logic [NI-1:0]            v_i;
  logic [NI-1:0]            yumi;
  logic [NI-1:0]            ready;
  logic [NI-1:0]            v_o;
  logic [NI-1:0][WIDTH-1:0] index;
  logic [NI-1:0][2:0]       bank;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int B  = bk(g);
    localparam int BW = (B <= 1) ? 1 : $clog2(B);
    logic [BW-1:0] bo;

    bsg_hash_bank_iter #(.banks_p(B), .width_p(WIDTH)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .addr_i    (addr[g]),
      .v_i       (v_i[g]),
      .ready_o   (ready[g]),
      .bank_o    (bo),
      .index_o   (index[g]),
      .v_o       (v_o[g]),
      .yumi_i    (yumi[g])
    );

    assign bank[g] = 3'(bo);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         g;
    logic [31:0] a;
    logic [2:0]  bank;
    logic [31:0] idx;
    int         acc;
    int         lat;
    int         dly;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Expectation comes straight from integer div/mod; latency from the bank count's power-of-two-ness.
  task automatic issue(input int g, input logic [31:0] a, input int dly);
    exp_t e;
    int   w;
    int   B;
    B = bk(g);
    v_i[g]  = 1'b1;
    addr[g] = a;
    w = 0;
    while (!ready[g] && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ready[g]) begin
      chk("accept_timeout", 64'(ready[g]), 64'd1);
      v_i[g] = 1'b0;
      return;
    end
    e.g    = g;
    e.a    = a;
    e.bank = 3'({32'b0, a} % 64'(B));
    e.idx  = 32'({32'b0, a} / 64'(B));
    e.acc  = cyc + 1;
    e.lat  = ((B & (B - 1)) == 0) ? 1 : WIDTH + 1;
    e.dly  = dly;
    sb.push_back(e);
    @(negedge clk);
    v_i[g] = 1'b0;
  endtask

  task automatic handle(input int g);
    exp_t        e;
    int          B;
    logic [63:0] recon;
    B = bk(g);
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_v_o: inst %0d presented bank=%0d index=0x%0h with nothing outstanding", g, bank[g], index[g]);
      yumi[g] = 1'b1;
      @(negedge clk);
      yumi[g] = 1'b0;
      return;
    end
    e = sb.pop_front();
    chk("instance", 64'(g), 64'(e.g));
    chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
    chk("bank", 64'(bank[g]), 64'(e.bank));
    chk("index", 64'(index[g]), 64'(e.idx));
    recon = 64'(index[g]) * 64'(B) + 64'(bank[g]);
    chk("identity", recon, 64'(e.a));
    chk("bank_range", 64'(32'(bank[g]) < B), 64'd1);
    for (int d = 0; d < e.dly; d++) begin
      @(negedge clk);
      chk("hold_v_o", 64'(v_o[g]), 64'd1);
      chk("hold_bank", 64'(bank[g]), 64'(e.bank));
      chk("hold_index", 64'(index[g]), 64'(e.idx));
      chk("hold_ready", 64'(ready[g]), 64'd0);
    end
    yumi[g] = 1'b1;
    @(negedge clk);
    yumi[g] = 1'b0;
    chk("release_v_o", 64'(v_o[g]), 64'd0);
    chk("release_ready", 64'(ready[g]), 64'd1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (reset_n && v_o[g]) handle(g);
      end
    end
  end

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || v_o != '0) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          g;
    int          r;
    logic [31:0] a;

    reset_n = 1'b0;
    v_i     = '0;
    yumi    = '0;
    addr    = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_ready", 64'(ready[i]), 64'd1);
      chk("reset_v_o", 64'(v_o[i]), 64'd0);
      chk("reset_bank", 64'(bank[i]), 64'd0);
      chk("reset_index", 64'(index[i]), 64'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    issue(0, 32'd100, 0);
    issue(0, 32'hFFFF_FFFF, 1);
    issue(0, 32'd2, 0);
    issue(0, 32'd0, 0);
    drain();
    issue(1, 32'h1D, 0);
    drain();
    issue(2, 32'hDEAD_BEEF, 2);
    drain();

    // Second address is presented while the first sits in DONE under backpressure.
    issue(0, 32'h1234_5678, 5);
    issue(0, 32'h0BAD_F00D, 0);
    drain();

    v_i[0]  = 1'b1;
    addr[0] = 32'd123456;
    @(negedge clk);
    v_i[0] = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_v_o", 64'(v_o[0]), 64'd0);
    chk("midreset_ready", 64'(ready[0]), 64'd1);
    chk("midreset_index", 64'(index[0]), 64'd0);
    chk("midreset_bank", 64'(bank[0]), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("postreset_v_o", 64'(v_o[0]), 64'd0);
    issue(0, 32'd7, 0);
    drain();

    for (int k = 0; k < 4; k++) begin
      g = (k == 0) ? 0 : k + 2;
      for (int n = 0; n < N_RAND; n++) begin
        r = $urandom_range(0, 9);
        a = $urandom;
        if (r == 0) a = 32'hFFFF_FFFF;
        else if (r == 1) a = $urandom_range(0, bk(g) - 1);
        issue(g, a, $urandom_range(0, 3));
      end
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
